// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared encodings for the execute stage: ALU functions,
//               multiply/divide operations, mf selects, MDU states and
//               forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLLV  = 4'd9;
    localparam logic [3:0] ALU_SRLV  = 4'd10;
    localparam logic [3:0] ALU_SRAV  = 4'd11;
    localparam logic [3:0] ALU_NOR   = 4'd12;
    localparam logic [3:0] ALU_LUI   = 4'd13;
    localparam logic [3:0] ALU_SLTU  = 4'd14;
    localparam logic [3:0] ALU_PASSB = 4'd15;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] MF_ALU = 2'd0;
    localparam logic [1:0] MF_HI  = 2'd1;
    localparam logic [1:0] MF_LO  = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
//               Works on magnitudes, then applies sign correction in FIX.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mt_hi_we,
    input  logic            mt_lo_we,
    input  logic [XLEN-1:0] mt_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    mdu_state_t      r_state;
    mdu_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_acc;     // product high half / partial remainder
    logic [XLEN-1:0] r_q;       // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] r_m;       // multiplicand / divisor magnitude
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_b_zero;
    logic            r_is_div;

    logic            w_go;
    logic            w_signed;
    logic            w_div_op;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic [XLEN:0]   w_div_diff;
    logic            w_qbit;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign w_go     = start && (r_state == S_IDLE) &&
                      (op == MD_MULT || op == MD_MULTU || w_div_op);
    assign w_a_neg  = w_signed & a[XLEN-1];
    assign w_b_neg  = w_signed & b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set
    assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    // Restoring divide step: keep the difference only when it did not borrow
    assign w_div_sh   = {r_acc, r_q[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_m};
    assign w_qbit     = ~w_div_diff[XLEN];

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_state_nxt = w_div_op ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:  if (r_cnt == LAST_STEP) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_zero <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_a_mag;
                        r_m      <= w_b_mag;
                        r_neg_a  <= w_a_neg;
                        r_neg_b  <= w_b_neg;
                        r_b_zero <= (b == '0);
                        r_is_div <= w_div_op;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_sum[XLEN:1];
                    r_q   <= {w_mul_sum[0], r_q[XLEN-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_qbit ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // Divide by zero naturally leaves |dividend| as remainder
                        r_lo <= r_b_zero ? '1 :
                                ((r_neg_a ^ r_neg_b) ? -r_q : r_q);
                        r_hi <= r_neg_a ? -r_acc : r_acc;
                    end else begin
                        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                        r_lo <= w_prod_fix[XLEN-1:0];
                    end
                end
                default: ;
            endcase
            if (mt_hi_we) r_hi <= mt_data;
            if (mt_lo_we) r_lo <= mt_data;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: rtl/ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mdu
// Description : MIPS execute stage: operand forwarding, operand muxes, ALU and
//               iterative MDU with HI/LO; stalls dependent MDU traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [RADDR-1:0] rs_addr,
    input  logic [RADDR-1:0] rt_addr,
    input  logic [XLEN-1:0]  rs_data,
    input  logic [XLEN-1:0]  rt_data,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic             exmem_regwrite,
    input  logic             memwb_regwrite,
    input  logic [XLEN-1:0]  exmem_data,
    input  logic [XLEN-1:0]  memwb_data,
    input  logic [3:0]       alu_op,
    input  logic             use_shamt,
    input  logic [4:0]       shamt,
    input  logic             use_imm,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       md_op,
    input  logic [1:0]       mf_sel,
    output logic [XLEN-1:0]  result,
    output logic [XLEN-1:0]  store_data,
    output logic             stall,
    output logic             md_busy
);

    localparam int SHW = $clog2(XLEN);

    logic [1:0]      w_sel_a;
    logic [1:0]      w_sel_b;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_sh;
    logic [XLEN-1:0] w_lui;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic            w_md_req;
    logic            w_issue;
    logic            w_start;

    function automatic logic [1:0] fwd_select(
        input logic [RADDR-1:0] src,
        input logic [RADDR-1:0] em_rd,
        input logic             em_we,
        input logic [RADDR-1:0] mw_rd,
        input logic             mw_we
    );
        if (src == '0)                      return FWD_RF;
        else if (em_we && (em_rd == src))   return FWD_EXMEM;
        else if (mw_we && (mw_rd == src))   return FWD_MEMWB;
        else                                return FWD_RF;
    endfunction

    assign w_sel_a = fwd_select(rs_addr, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    assign w_sel_b = fwd_select(rt_addr, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);

    assign w_fwd_a = (w_sel_a == FWD_EXMEM) ? exmem_data :
                     (w_sel_a == FWD_MEMWB) ? memwb_data : rs_data;
    assign w_fwd_b = (w_sel_b == FWD_EXMEM) ? exmem_data :
                     (w_sel_b == FWD_MEMWB) ? memwb_data : rt_data;

    assign w_a   = use_shamt ? {{(XLEN-5){1'b0}}, shamt} : w_fwd_a;
    assign w_b   = use_imm ? imm : w_fwd_b;
    assign w_sh  = w_a[SHW-1:0];
    assign w_lui = imm << 16;

    always_comb begin
        w_alu = '0;
        case (alu_op)
            ALU_AND:   w_alu = w_a & w_b;
            ALU_OR:    w_alu = w_a | w_b;
            ALU_ADD:   w_alu = w_a + w_b;
            ALU_XOR:   w_alu = w_a ^ w_b;
            ALU_SLL,
            ALU_SLLV:  w_alu = w_b << w_sh;
            ALU_SRL,
            ALU_SRLV:  w_alu = w_b >> w_sh;
            ALU_SUB:   w_alu = w_a - w_b;
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            ALU_SRA,
            ALU_SRAV:  w_alu = $signed(w_b) >>> w_sh;
            ALU_NOR:   w_alu = ~(w_a | w_b);
            ALU_LUI:   w_alu = w_lui;
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            ALU_PASSB: w_alu = w_b;
            default:   w_alu = w_b;
        endcase
    end

    // Only MDU-touching instructions wait on the MDU; plain ALU ops flow past
    assign w_md_req = (md_op != MD_NONE) || (mf_sel != MF_ALU);
    assign stall    = ex_valid && md_busy && w_md_req;
    assign w_issue  = ex_valid && !stall;
    assign w_start  = w_issue && (md_op == MD_MULT || md_op == MD_MULTU ||
                                  md_op == MD_DIV  || md_op == MD_DIVU);

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .op       (md_op),
        .a        (w_fwd_a),
        .b        (w_fwd_b),
        .mt_hi_we (w_issue && (md_op == MD_MTHI)),
        .mt_lo_we (w_issue && (md_op == MD_MTLO)),
        .mt_data  (w_fwd_a),
        .hi       (w_hi),
        .lo       (w_lo),
        .busy     (md_busy)
    );

    assign result     = (mf_sel == MF_HI) ? w_hi :
                        (mf_sel == MF_LO) ? w_lo : w_alu;
    assign store_data = w_fwd_b;

endmodule
`default_nettype wire

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the pipelined MIPS core. It combines operand forwarding, the shamt and immediate operand muxes, the main ALU, and a new iterative multiply/divide unit (MDU) with architectural HI/LO registers. It sits between the ID/EX and EX/MEM pipeline registers. It raises a stall toward the hazard logic while the MDU is busy.

## Interface
- XLEN, 32, datapath width (≥8, even)
- RADDR, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on reset
- ex_valid  in  1  ID/EX holds a real instruction
- rs_addr, rt_addr  in  RADDR  source register numbers
- rs_data, rt_data  in  XLEN  register-file read data
- exmem_rd, memwb_rd  in  RADDR  destination registers of older instructions
- exmem_regwrite, memwb_regwrite  in  1  older instruction writes a register
- exmem_data, memwb_data  in  XLEN  forwarding values
- alu_op  in  4  ALU function: 0 and, 1 or, 2 add, 3 xor, 4 sll, 5 srl, 6 sub, 7 slt (signed), 8 sra, 9 sllv, 10 srlv, 11 srav, 12 nor, 13 lui, 14 sltu, 15 pass B
- use_shamt  in  1  A operand = zero-extended shamt
- shamt  in  5  shift amount
- use_imm  in  1  B operand = imm
- imm  in  XLEN  pre-extended immediate
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- mf_sel  in  2  0 ALU result, 1 mfhi, 2 mflo
- result  out  XLEN  EX result to EX/MEM (combinational)
- store_data  out  XLEN  forwarded rt value for sw
- stall  out  1  hold IF/ID/EX, insert bubble into EX/MEM
- md_busy  out  1  MDU iterating

## Operation
- Forwarding per operand: EX/MEM match (regwrite, rd≠0, rd==src) wins; else MEM/WB match; else register file. Register 0 is never forwarded.
- A = use_shamt ? {0,shamt} : fwdA. B = use_imm ? imm : fwdB.
- Shift amounts use A[log2(XLEN)-1:0]. lui returns {imm[15:0],0}. Undefined codes do not exist: all 16 codes are defined.
- result = mf_sel==1 ? HI : mf_sel==2 ? LO : ALU out.
- MDU FSM states are IDLE, MUL, DIV, FIX.
  - IDLE→MUL/DIV when ex_valid & !stall & md_op∈{1..4}. Operands are latched as magnitudes and signs are recorded for signed ops.
  - MUL/DIV: one radix-2 step per cycle (shift-add multiply; restoring divide), XLEN steps.
  - FIX: apply sign correction and write HI/LO, then go to IDLE.
- mult/multu: {HI,LO} = 2·XLEN-bit product.
- div/divu: LO = quotient, HI = remainder; the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend.
- Signed MIN/−1: LO = MIN, HI = 0.
- mthi/mtlo write fwdA into HI/LO at the clock edge when not stalled.
- md_busy = state≠IDLE.
- stall = ex_valid & md_busy & (md_op≠0 | mf_sel≠0). ALU-only instructions proceed while the MDU runs.
- A new MDU op, mf, or mt is held upstream by stall. It is not lost or re-ordered.

## Timing
- Reset values: HI=0, LO=0, state=IDLE, md_busy=0, stall=0. The combinational outputs follow from the inputs.
- ALU path latency is 0 cycles (combinational into EX/MEM).
- MDU latency: if a start is accepted at edge N, md_busy is high from N through N+XLEN+1. HI/LO are updated at edge N+XLEN+1. An mf in the following cycle reads the new value.
- A dependent mf issued back-to-back stalls exactly XLEN+1 cycles.
- Reset asserted mid-operation aborts the operation: IDLE on the next edge, and HI/LO are cleared.
- A start and an mt in the same cycle cannot occur (one instruction per cycle).

## Structure
- Package ex_pkg holds:
  - alu_op localparams (ALU_AND…ALU_PASSB)
  - md_op codes (MD_NONE…MD_MTLO)
  - mf_sel codes
  - MDU state enum
  - forwarding-select codes (FWD_RF, FWD_EXMEM, FWD_MEMWB)
- Sub-module mdu_iter contains the FSM, the step counter, the HI/LO registers and sign fix-up. Interface: start, op, a, b, hi, lo, busy, plus the mt write ports.
- The forwarding, operand muxes and ALU stay in the top level.

## Test plan
- Forwarding priority: rs=3, exmem_rd=3/regwrite=1/data=0x11, memwb_rd=3/data=0x22, add with rt_data=1 → result 0x12. With rs=0 under the same matches → rs_data is used.
- Signed vs unsigned: A=0xFFFFFFFF, B=1: slt → 1, sltu → 0. sra of 0x80000000 by shamt 4 → 0xF8000000.
- mult −3 × 5 then mflo back-to-back → stall high 33 cycles, then LO=0xFFFFFFF1, HI=0xFFFFFFFF. multu 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=1.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → LO=0xFFFFFFFF, HI=7. div 0x80000000 / −1 → LO=0x80000000, HI=0.
- Independent add issued during busy → no stall, correct result. mthi during busy → stalled until IDLE, then HI written.
- Reset at step 10 of a divide → md_busy=0, HI=LO=0 next cycle. A following mfhi returns 0 with no stall.
